multibank_buffer: RTL and testbench

Parametrised N-bank frame buffer for the audio sample path, successor to the two-buffer ping-pong scheme. A writer fills one bank at a time and commits it. A reader consumes committed banks in commit order and releases each when done. With NBANKS > 2 the writer and reader run decoupled by up to NBANKS frames, and the block flags overrun instead of silently stalling. It sits between the mic deserialiser/filter writer and the beamforming reader.

---
 rtl/buffer_pkg.sv | 19 +
 rtl/ram_sdp.sv | 25 ++
 rtl/multibank_buffer.sv | 112 +++++++++++
 tb/tb_multibank_buffer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared widths and helpers for the multibank frame buffer and its RAM banks.
package buffer_pkg;

   localparam int OVR_W = 16;

   function automatic int bankIdxWidth(input int nBanks);
      return (nBanks > 2) ? $clog2(nBanks) : 1;
   endfunction

   function automatic int occWidth(input int nBanks);
      return $clog2(nBanks + 1);
   endfunction

   // Counts up to all-ones and then holds there.
   function automatic logic [OVR_W-1:0] satInc(input logic [OVR_W-1:0] v);
      return (v == '1) ? v : v + OVR_W'(1);
   endfunction

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM bank: one write port, one registered read port, array not reset.
module ram_sdp #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_wren,
   input  logic [AW-1:0]    i_wAddr,
   input  logic [WIDTH-1:0] i_wData,
   input  logic [AW-1:0]    i_rAddr,
   output logic [WIDTH-1:0] o_rQ
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Read-before-write on a same-address collision returns the old word.
   always_ff @(posedge i_clk) begin
      if (i_wren) begin
         r_mem[i_wAddr] <= i_wData;
      end
      o_rQ <= r_mem[i_rAddr];
   end

endmodule

// File: rtl/multibank_buffer.sv
// N-bank frame buffer: writer fills and commits banks, reader consumes them in commit
// order and releases them; commits with no free bank are counted as overruns.
module multibank_buffer
   import buffer_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 256,
   parameter int NBANKS = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int OW    = occWidth(NBANKS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    w_addr,
   input  logic [WIDTH-1:0] w_data,
   input  logic             wren,
   input  logic             w_commit,
   output logic             w_ready,
   input  logic [AW-1:0]    r_addr,
   output logic [WIDTH-1:0] r_q,
   input  logic             r_release,
   output logic             r_valid,
   output logic [OW-1:0]    occupancy,
   output logic [15:0]      overrun_cnt
);

   localparam int BW = bankIdxWidth(NBANKS);
   localparam logic [OW-1:0] OCC_FULL  = OW'(NBANKS);
   localparam logic [BW-1:0] LAST_BANK = BW'(NBANKS - 1);

   logic [BW-1:0]    r_wPtr;
   logic [BW-1:0]    r_rPtr;
   logic [BW-1:0]    r_rSel;
   logic [OW-1:0]    r_occupancy;
   logic [OW-1:0]    w_occNext;
   logic             r_wReady;
   logic             r_rValid;
   logic [OVR_W-1:0] r_overrunCnt;
   logic             w_commitOk;
   logic             w_releaseOk;
   logic [WIDTH-1:0] w_bankQ [NBANKS];

   function automatic logic [BW-1:0] nextBank(input logic [BW-1:0] idx);
      return (idx == LAST_BANK) ? '0 : idx + BW'(1);
   endfunction

   assign w_commitOk  = w_commit & r_wReady;
   assign w_releaseOk = r_release & r_rValid;

   // Commit and release both judge against the pre-edge occupancy, so a matched pair cancels.
   always_comb begin
      w_occNext = r_occupancy;
      if (w_commitOk && !w_releaseOk) begin
         w_occNext = r_occupancy + OW'(1);
      end else if (!w_commitOk && w_releaseOk) begin
         w_occNext = r_occupancy - OW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wPtr       <= '0;
         r_rPtr       <= '0;
         r_occupancy  <= '0;
         r_wReady     <= 1'b1;
         r_rValid     <= 1'b0;
         r_overrunCnt <= '0;
      end else begin
         if (w_commitOk) begin
            r_wPtr <= nextBank(r_wPtr);
         end
         if (w_releaseOk) begin
            r_rPtr <= nextBank(r_rPtr);
         end
         if (w_commit && !r_wReady) begin
            r_overrunCnt <= satInc(r_overrunCnt);
         end
         r_occupancy <= w_occNext;
         r_wReady    <= (w_occNext != OCC_FULL);
         r_rValid    <= (w_occNext != '0);
      end
   end

   // The bank select travels alongside the read address so a read issued with a release
   // still returns data from the bank being released.
   always_ff @(posedge clk) begin
      r_rSel <= r_rPtr;
   end

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      logic w_bankWe;
      assign w_bankWe = wren & r_wReady & (r_wPtr == BW'(b));
      ram_sdp #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_ram (
         .i_clk   (clk),
         .i_wren  (w_bankWe),
         .i_wAddr (w_addr),
         .i_wData (w_data),
         .i_rAddr (r_addr),
         .o_rQ    (w_bankQ[b])
      );
   end

   assign r_q         = w_bankQ[r_rSel];
   assign w_ready     = r_wReady;
   assign r_valid     = r_rValid;
   assign occupancy   = r_occupancy;
   assign overrun_cnt = r_overrunCnt;

endmodule

// File: tb/tb_multibank_buffer.sv
// Directed bench for multibank_buffer: a 4-bank instance for ordering, overrun and reset,
// and a 3-bank instance for non-power-of-two pointer wrap.
module tb_multibank_buffer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clk;

   logic             reset4;
   logic [AW-1:0]    wAddr4;
   logic [WIDTH-1:0] wData4;
   logic             wren4;
   logic             wCommit4;
   logic             wReady4;
   logic [AW-1:0]    rAddr4;
   logic [WIDTH-1:0] rQ4;
   logic             rRelease4;
   logic             rValid4;
   logic [2:0]       occ4;
   logic [15:0]      ovr4;

   logic             reset3;
   logic [AW-1:0]    wAddr3;
   logic [WIDTH-1:0] wData3;
   logic             wren3;
   logic             wCommit3;
   logic             wReady3;
   logic [AW-1:0]    rAddr3;
   logic [WIDTH-1:0] rQ3;
   logic             rRelease3;
   logic             rValid3;
   logic [1:0]       occ3;
   logic [15:0]      ovr3;

   int testsRun;
   int testsFailed;

   multibank_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NBANKS(4)) dut4 (
      .clk         (clk),
      .reset       (reset4),
      .w_addr      (wAddr4),
      .w_data      (wData4),
      .wren        (wren4),
      .w_commit    (wCommit4),
      .w_ready     (wReady4),
      .r_addr      (rAddr4),
      .r_q         (rQ4),
      .r_release   (rRelease4),
      .r_valid     (rValid4),
      .occupancy   (occ4),
      .overrun_cnt (ovr4)
   );

   multibank_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NBANKS(3)) dut3 (
      .clk         (clk),
      .reset       (reset3),
      .w_addr      (wAddr3),
      .w_data      (wData3),
      .wren        (wren3),
      .w_commit    (wCommit3),
      .w_ready     (wReady3),
      .r_addr      (rAddr3),
      .r_q         (rQ3),
      .r_release   (rRelease3),
      .r_valid     (rValid3),
      .occupancy   (occ3),
      .overrun_cnt (ovr3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeFrame4(input int tag, input int nWords);
      for (int a = 0; a < nWords; a++) begin
         wAddr4 = AW'(a);
         wData4 = WIDTH'(tag * 256 + a);
         wren4  = 1'b1;
         tick();
      end
      wren4 = 1'b0;
   endtask

   task automatic commit4();
      wCommit4 = 1'b1;
      tick();
      wCommit4 = 1'b0;
   endtask

   task automatic release4();
      rRelease4 = 1'b1;
      tick();
      rRelease4 = 1'b0;
   endtask

   task automatic read4(input int a, output logic [WIDTH-1:0] q);
      rAddr4 = AW'(a);
      tick();
      q = rQ4;
   endtask

   task automatic read3(input int a, output logic [WIDTH-1:0] q);
      rAddr3 = AW'(a);
      tick();
      q = rQ3;
   endtask

   task automatic test_reset();
      reset4 = 1'b1;
      reset3 = 1'b1;
      tick();
      tick();
      reset4 = 1'b0;
      reset3 = 1'b0;
      tick();
      testsRun++;
      if (occ4 !== 3'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_occupancy: got %0d, expected 0", occ4);
      end
      testsRun++;
      if (wReady4 !== 1'b1 || rValid4 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags: got w_ready=%b r_valid=%b, expected 1 0", wReady4, rValid4);
      end
      testsRun++;
      if (ovr4 !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_overrun: got %0d, expected 0", ovr4);
      end
   endtask

   task automatic test_write_read();
      logic [WIDTH-1:0] q;
      writeFrame4(0, DEPTH);
      commit4();
      testsRun++;
      if (rValid4 !== 1'b1 || occ4 !== 3'd1) begin
         testsFailed++;
         $display("[TB] FAIL first_commit: got r_valid=%b occ=%0d, expected 1 1", rValid4, occ4);
      end
      writeFrame4(1, DEPTH);
      commit4();
      writeFrame4(2, DEPTH);
      commit4();
      testsRun++;
      if (occ4 !== 3'd3 || wReady4 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL three_frames: got occ=%0d w_ready=%b, expected 3 1", occ4, wReady4);
      end
      read4(5, q);
      testsRun++;
      if (q !== 32'd5) begin
         testsFailed++;
         $display("[TB] FAIL read_frame0_addr5: got %0d, expected 5", q);
      end
      read4(7, q);
      testsRun++;
      if (q !== 32'd7) begin
         testsFailed++;
         $display("[TB] FAIL read_frame0_addr7: got %0d, expected 7", q);
      end
   endtask

   task automatic test_overrun();
      logic [WIDTH-1:0] q;
      writeFrame4(3, DEPTH);
      commit4();
      testsRun++;
      if (occ4 !== 3'd4 || wReady4 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL full: got occ=%0d w_ready=%b, expected 4 0", occ4, wReady4);
      end
      for (int a = 0; a < DEPTH; a++) begin
         wAddr4 = AW'(a);
         wData4 = 32'hDEAD;
         wren4  = 1'b1;
         tick();
      end
      wren4 = 1'b0;
      commit4();
      testsRun++;
      if (ovr4 !== 16'd1 || occ4 !== 3'd4) begin
         testsFailed++;
         $display("[TB] FAIL overrun_commit: got ovr=%0d occ=%0d, expected 1 4", ovr4, occ4);
      end
      read4(3, q);
      testsRun++;
      if (q !== 32'd3) begin
         testsFailed++;
         $display("[TB] FAIL dropped_write: got %0d, expected 3", q);
      end
      release4();
      testsRun++;
      if (wReady4 !== 1'b1 || occ4 !== 3'd3) begin
         testsFailed++;
         $display("[TB] FAIL release_after_full: got w_ready=%b occ=%0d, expected 1 3", wReady4, occ4);
      end
   endtask

   task automatic test_simultaneous();
      logic [WIDTH-1:0] q;
      release4();
      writeFrame4(4, DEPTH);
      wCommit4  = 1'b1;
      rRelease4 = 1'b1;
      tick();
      wCommit4  = 1'b0;
      rRelease4 = 1'b0;
      testsRun++;
      if (occ4 !== 3'd2 || rValid4 !== 1'b1 || wReady4 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL commit_release_same: got occ=%0d r_valid=%b w_ready=%b, expected 2 1 1", occ4, rValid4, wReady4);
      end
      read4(2, q);
      testsRun++;
      if (q !== 32'd770) begin
         testsFailed++;
         $display("[TB] FAIL order_frame3: got %0d, expected 770", q);
      end
      rAddr4    = 3'd6;
      rRelease4 = 1'b1;
      tick();
      rRelease4 = 1'b0;
      q = rQ4;
      testsRun++;
      if (q !== 32'd774 || occ4 !== 3'd1) begin
         testsFailed++;
         $display("[TB] FAIL read_with_release: got q=%0d occ=%0d, expected 774 1", q, occ4);
      end
      read4(2, q);
      testsRun++;
      if (q !== 32'd1026) begin
         testsFailed++;
         $display("[TB] FAIL order_frame4: got %0d, expected 1026", q);
      end
      release4();
   endtask

   task automatic test_release_empty();
      logic [WIDTH-1:0] q;
      release4();
      testsRun++;
      if (occ4 !== 3'd0 || rValid4 !== 1'b0 || wReady4 !== 1'b1 || ovr4 !== 16'd1) begin
         testsFailed++;
         $display("[TB] FAIL release_empty: got occ=%0d r_valid=%b w_ready=%b ovr=%0d, expected 0 0 1 1", occ4, rValid4, wReady4, ovr4);
      end
      writeFrame4(5, DEPTH);
      commit4();
      read4(1, q);
      testsRun++;
      if (q !== 32'd1281) begin
         testsFailed++;
         $display("[TB] FAIL rptr_held: got %0d, expected 1281", q);
      end
      release4();
   endtask

   task automatic test_reset_midframe();
      commit4();
      commit4();
      commit4();
      testsRun++;
      if (occ4 !== 3'd3) begin
         testsFailed++;
         $display("[TB] FAIL pre_reset_occ: got %0d, expected 3", occ4);
      end
      reset4 = 1'b1;
      tick();
      reset4 = 1'b0;
      testsRun++;
      if (occ4 !== 3'd0 || rValid4 !== 1'b0 || wReady4 !== 1'b1 || ovr4 !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL midframe_reset: got occ=%0d r_valid=%b w_ready=%b ovr=%0d, expected 0 0 1 0", occ4, rValid4, wReady4, ovr4);
      end
   endtask

   task automatic test_overrun_saturate();
      for (int i = 0; i < 4; i++) begin
         commit4();
      end
      wCommit4 = 1'b1;
      repeat (65534) tick();
      testsRun++;
      if (ovr4 !== 16'hFFFE) begin
         testsFailed++;
         $display("[TB] FAIL overrun_count: got %0h, expected fffe", ovr4);
      end
      repeat (6) tick();
      wCommit4 = 1'b0;
      testsRun++;
      if (ovr4 !== 16'hFFFF || occ4 !== 3'd4) begin
         testsFailed++;
         $display("[TB] FAIL overrun_saturate: got ovr=%0h occ=%0d, expected ffff 4", ovr4, occ4);
      end
   endtask

   task automatic test_wrap();
      logic [WIDTH-1:0] q;
      for (int k = 0; k < 7; k++) begin
         for (int a = 0; a < 2; a++) begin
            wAddr3 = AW'(a);
            wData3 = WIDTH'(k * 256 + a);
            wren3  = 1'b1;
            tick();
         end
         wren3    = 1'b0;
         wCommit3 = 1'b1;
         tick();
         wCommit3 = 1'b0;
         read3(1, q);
         testsRun++;
         if (q !== WIDTH'(k * 256 + 1)) begin
            testsFailed++;
            $display("[TB] FAIL wrap_frame%0d: got %0d, expected %0d", k, q, k * 256 + 1);
         end
         rRelease3 = 1'b1;
         tick();
         rRelease3 = 1'b0;
      end
      wAddr3 = 3'd0;
      wData3 = 32'd1792;
      wren3  = 1'b1;
      tick();
      wren3    = 1'b0;
      wCommit3 = 1'b1;
      tick();
      wCommit3 = 1'b0;
      testsRun++;
      if (occ3 !== 2'd1 || rValid3 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL wrap_occ: got occ=%0d r_valid=%b, expected 1 1", occ3, rValid3);
      end
      read3(0, q);
      testsRun++;
      if (q !== 32'd1792) begin
         testsFailed++;
         $display("[TB] FAIL wrap_new_word: got %0d, expected 1792", q);
      end
      // Word 1 was not rewritten, so it still holds frame 4's value if both pointers sit on bank 1.
      read3(1, q);
      testsRun++;
      if (q !== 32'd1025) begin
         testsFailed++;
         $display("[TB] FAIL wrap_bank1: got %0d, expected 1025", q);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      {reset4, wren4, wCommit4, rRelease4} = '0;
      {reset3, wren3, wCommit3, rRelease3} = '0;
      wAddr4 = '0;
      wData4 = '0;
      rAddr4 = '0;
      wAddr3 = '0;
      wData3 = '0;
      rAddr3 = '0;
      test_reset();
      test_write_read();
      test_overrun();
      test_simultaneous();
      test_release_empty();
      test_reset_midframe();
      test_wrap();
      test_overrun_saturate();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
